// File: rtl/child_seq_ctrl.sv
// rtl/child_seq_ctrl.sv - in-order child launch sequencer; optional per-child timeout via CHILD_SEQ_TIMEOUT_EN
module child_seq_ctrl #(
  parameter  int NUM_CHILD   = 5,
  parameter  int TIMEOUT_W   = 8,
  parameter  int TIMEOUT_CYC = 200,
  localparam int IDX_W       = $clog2(NUM_CHILD)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start_i,
  input  logic                 abort_i,
  output logic [NUM_CHILD-1:0] child_start_o,
  input  logic [NUM_CHILD-1:0] child_done_i,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [IDX_W-1:0]     cur_idx_o,
  output logic                 err_o,
  output logic [IDX_W-1:0]     err_idx_o
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LAUNCH = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_FINISH = 3'd3;
  localparam logic [2:0] S_ERROR  = 3'd4;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHILD - 1);

  if (NUM_CHILD < 2 || TIMEOUT_CYC < 1 || TIMEOUT_CYC > (2 ** TIMEOUT_W) - 1) begin : g_bad_cfg
    $error("child_seq_ctrl: invalid NUM_CHILD/TIMEOUT_CYC configuration");
  end

  logic [2:0]       r_state;
  logic [IDX_W-1:0] r_idx;
  logic             w_done;
  logic             w_last;

`ifdef CHILD_SEQ_TIMEOUT_EN
  localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT_CYC - 1);
  logic [TIMEOUT_W-1:0] r_cnt;
  logic                 r_err;
  logic [IDX_W-1:0]     r_err_idx;
`endif

  // Only the awaited child's done matters; the others are ignored.
  assign w_done = child_done_i[r_idx];
  assign w_last = (r_idx == LAST_IDX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
`ifdef CHILD_SEQ_TIMEOUT_EN
      r_cnt     <= '0;
      r_err     <= 1'b0;
      r_err_idx <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start_i) begin
            r_state <= S_LAUNCH;
            r_idx   <= '0;
          end
        end
        S_LAUNCH: begin
          if (abort_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else begin
            r_state <= S_WAIT;
`ifdef CHILD_SEQ_TIMEOUT_EN
            r_cnt <= '0;
`endif
          end
        end
        S_WAIT: begin
          if (abort_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
          end else if (w_done) begin
            if (w_last) begin
              r_state <= S_FINISH;
            end else begin
              r_state <= S_LAUNCH;
              r_idx   <= r_idx + IDX_W'(1);
            end
`ifdef CHILD_SEQ_TIMEOUT_EN
          end else if (r_cnt == CNT_LAST) begin
            r_state   <= S_ERROR;
            r_err     <= 1'b1;
            r_err_idx <= r_idx;
          end else begin
            r_cnt <= r_cnt + TIMEOUT_W'(1);
`endif
          end
        end
        S_FINISH: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
`ifdef CHILD_SEQ_TIMEOUT_EN
        // ERROR keeps idx visible until a new start; abort cannot clear it.
        S_ERROR: begin
          if (start_i) begin
            r_state   <= S_LAUNCH;
            r_idx     <= '0;
            r_err     <= 1'b0;
            r_err_idx <= '0;
          end
        end
`endif
        default: begin
          r_state <= S_IDLE;
          r_idx   <= '0;
        end
      endcase
    end
  end

  always_comb begin
    child_start_o = '0;
    if (r_state == S_LAUNCH) child_start_o[r_idx] = 1'b1;
  end

  assign busy_o    = (r_state != S_IDLE) && (r_state != S_ERROR);
  assign done_o    = (r_state == S_FINISH);
  assign cur_idx_o = r_idx;

`ifdef CHILD_SEQ_TIMEOUT_EN
  assign err_o     = r_err;
  assign err_idx_o = r_err_idx;
`else
  assign err_o     = 1'b0;
  assign err_idx_o = '0;
`endif

endmodule

// File: tb/tb_child_seq_ctrl.sv
// tb/tb_child_seq_ctrl.sv - self-checking bench for child_seq_ctrl (vectors, directed sequences, random vs model)
module tb_child_seq_ctrl;

  localparam int N  = 5;
  localparam int IW = 3;
  localparam int TC = 10;

  logic          clk;
  logic          rst;
  logic          start_i;
  logic          abort_i;
  logic [N-1:0]  child_start_o;
  logic [N-1:0]  child_done_i;
  logic          busy_o;
  logic          done_o;
  logic [IW-1:0] cur_idx_o;
  logic          err_o;
  logic [IW-1:0] err_idx_o;

  int n_total = 0;
  int n_bad   = 0;

  child_seq_ctrl #(
    .NUM_CHILD  (N),
    .TIMEOUT_W  (8),
    .TIMEOUT_CYC(TC)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .start_i      (start_i),
    .abort_i      (abort_i),
    .child_start_o(child_start_o),
    .child_done_i (child_done_i),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .cur_idx_o    (cur_idx_o),
    .err_o        (err_o),
    .err_idx_o    (err_idx_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: which phase of the job we are in, which child is served, how long we have waited.
  typedef enum int {P_IDLE, P_LAUNCH, P_WAIT, P_FINISH, P_ERROR} phase_t;
  phase_t m_phase = P_IDLE;
  int     m_idx = 0;
  int     m_waited = 0;
  bit     m_err = 0;
  int     m_err_idx = 0;
  bit     m_timeout_on;

  initial begin
`ifdef CHILD_SEQ_TIMEOUT_EN
    m_timeout_on = 1'b1;
`else
    m_timeout_on = 1'b0;
`endif
  end

  task automatic model_update(input logic s, input logic a, input logic [N-1:0] d, input logic r);
    if (r) begin
      m_phase = P_IDLE; m_idx = 0; m_waited = 0; m_err = 0; m_err_idx = 0;
    end else begin
      case (m_phase)
        P_IDLE:   if (s) begin m_phase = P_LAUNCH; m_idx = 0; end
        P_LAUNCH: if (a) begin m_phase = P_IDLE; m_idx = 0; end
                  else begin m_phase = P_WAIT; m_waited = 0; end
        P_WAIT: begin
          if (a) begin
            m_phase = P_IDLE; m_idx = 0;
          end else if (d[m_idx]) begin
            if (m_idx == N - 1) m_phase = P_FINISH;
            else begin m_idx = m_idx + 1; m_phase = P_LAUNCH; end
          end else if (m_timeout_on && m_waited == TC - 1) begin
            m_phase = P_ERROR; m_err = 1; m_err_idx = m_idx;
          end else begin
            m_waited = m_waited + 1;
          end
        end
        P_FINISH: begin m_phase = P_IDLE; m_idx = 0; end
        P_ERROR:  if (s) begin m_phase = P_LAUNCH; m_idx = 0; m_err = 0; m_err_idx = 0; end
        default:  m_phase = P_IDLE;
      endcase
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Drive one cycle of inputs, clock it, and compare every output with the model.
  task automatic tick(input logic s, input logic a, input logic [N-1:0] d, input logic r, input string tag);
    logic [31:0] exp_start;
    start_i = s; abort_i = a; child_done_i = d; rst = r;
    @(posedge clk);
    model_update(s, a, d, r);
    #1;
    exp_start = (m_phase == P_LAUNCH) ? (32'd1 << m_idx) : 32'd0;
    check({tag, " start"},   child_start_o, exp_start);
    check({tag, " busy"},    busy_o, (m_phase == P_LAUNCH || m_phase == P_WAIT || m_phase == P_FINISH) ? 1 : 0);
    check({tag, " done"},    done_o, (m_phase == P_FINISH) ? 1 : 0);
    check({tag, " idx"},     cur_idx_o, m_idx);
    check({tag, " err"},     err_o, m_err ? 1 : 0);
    check({tag, " err_idx"}, err_idx_o, m_err_idx);
  endtask

  typedef struct {
    logic         s;
    logic         a;
    logic [N-1:0] d;
    logic [N-1:0] xs;
    logic         xb;
    logic         xd;
    logic [IW-1:0] xi;
  } vec_t;

  vec_t tbl[14];

  initial begin
    logic [N-1:0] d;

    // Stray done, restart attempt, abort racing done, abort in LAUNCH, start+abort in IDLE.
    tbl[0]  = '{1'b1, 1'b0, 5'b00000, 5'b00001, 1'b1, 1'b0, 3'd0};
    tbl[1]  = '{1'b0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 3'd0};
    tbl[2]  = '{1'b0, 1'b0, 5'b00001, 5'b00010, 1'b1, 1'b0, 3'd1};
    tbl[3]  = '{1'b0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 3'd1};
    tbl[4]  = '{1'b0, 1'b0, 5'b01000, 5'b00000, 1'b1, 1'b0, 3'd1};
    tbl[5]  = '{1'b1, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 3'd1};
    tbl[6]  = '{1'b0, 1'b0, 5'b00010, 5'b00100, 1'b1, 1'b0, 3'd2};
    tbl[7]  = '{1'b0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 3'd2};
    tbl[8]  = '{1'b0, 1'b1, 5'b00100, 5'b00000, 1'b0, 1'b0, 3'd0};
    tbl[9]  = '{1'b0, 1'b0, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'd0};
    tbl[10] = '{1'b1, 1'b0, 5'b00000, 5'b00001, 1'b1, 1'b0, 3'd0};
    tbl[11] = '{1'b0, 1'b1, 5'b00000, 5'b00000, 1'b0, 1'b0, 3'd0};
    tbl[12] = '{1'b1, 1'b1, 5'b00000, 5'b00001, 1'b1, 1'b0, 3'd0};
    tbl[13] = '{1'b0, 1'b0, 5'b00000, 5'b00000, 1'b1, 1'b0, 3'd0};

    start_i = 0; abort_i = 0; child_done_i = '0; rst = 1;

    // Reset state
    tick(0, 0, '0, 1, "rst");
    tick(1, 1, '1, 1, "rst2");
    check("rst start", child_start_o, 0);
    check("rst busy", busy_o, 0);
    check("rst done", done_o, 0);
    check("rst idx", cur_idx_o, 0);
    check("rst err", err_o, 0);

    // Nominal: each child answers 3 cycles after its launch pulse
    tick(1, 0, '0, 0, "nom");
    for (int c = 1; c <= 21; c++) begin
      check($sformatf("nom c%0d start", c), child_start_o,
            (c % 4 == 1 && c <= 17) ? (32'd1 << ((c - 1) / 4)) : 32'd0);
      check($sformatf("nom c%0d done", c), done_o, (c == 21) ? 1 : 0);
      check($sformatf("nom c%0d busy", c), busy_o, 1);
      d = (c % 4 == 0 && c >= 4 && c <= 20) ? N'(1 << (c / 4 - 1)) : '0;
      tick(0, 0, d, 0, "nom");
    end
    check("nom end busy", busy_o, 0);
    check("nom end done", done_o, 0);

    // Zero-delay children: done_o at cycle 11
    tick(1, 0, '1, 0, "zd");
    for (int c = 1; c <= 12; c++) begin
      check($sformatf("zd c%0d done", c), done_o, (c == 11) ? 1 : 0);
      tick(0, 0, '1, 0, "zd");
    end

    // Table-driven vectors
    tick(0, 0, '0, 1, "tblrst");
    for (int i = 0; i < 14; i++) begin
      tick(tbl[i].s, tbl[i].a, tbl[i].d, 1'b0, "tblm");
      check($sformatf("vec%0d start", i), child_start_o, tbl[i].xs);
      check($sformatf("vec%0d busy", i), busy_o, tbl[i].xb);
      check($sformatf("vec%0d done", i), done_o, tbl[i].xd);
      check($sformatf("vec%0d idx", i), cur_idx_o, tbl[i].xi);
      check($sformatf("vec%0d err", i), err_o, 0);
    end

    // Child 2 never responds
    tick(0, 0, '0, 1, "torst");
    tick(1, 0, 5'b00011, 0, "to");
`ifdef CHILD_SEQ_TIMEOUT_EN
    for (int c = 1; c <= 15; c++) begin
      if (c == 15) check("to pre err", err_o, 0);
      tick(0, 0, 5'b00011, 0, "to");
    end
    check("to err", err_o, 1);
    check("to err_idx", err_idx_o, 2);
    check("to busy", busy_o, 0);
    check("to idx", cur_idx_o, 2);
    tick(0, 1, '0, 0, "toab");
    check("to abort keeps err", err_o, 1);
    tick(1, 0, '0, 0, "tost");
    check("to restart err", err_o, 0);
    check("to restart start", child_start_o, 5'b00001);
`else
    for (int c = 1; c <= 300; c++) tick(0, 0, 5'b00011, 0, "to");
    check("noto err", err_o, 0);
    check("noto busy", busy_o, 1);
    check("noto idx", cur_idx_o, 2);
`endif

    // Reset while waiting on child 4
    tick(0, 0, '0, 1, "rmrst");
    tick(1, 0, 5'b01111, 0, "rm");
    for (int c = 1; c < 10; c++) tick(0, 0, 5'b01111, 0, "rm");
    check("rm pre idx", cur_idx_o, 4);
    check("rm pre busy", busy_o, 1);
    tick(0, 0, 5'b11111, 1, "rm");
    check("rm start", child_start_o, 0);
    check("rm busy", busy_o, 0);
    check("rm done", done_o, 0);
    check("rm idx", cur_idx_o, 0);
    tick(0, 0, 5'b11111, 0, "rm2");
    check("rm2 done", done_o, 0);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      tick($urandom_range(0, 7) == 0, $urandom_range(0, 29) == 0,
           N'($urandom & $urandom), $urandom_range(0, 299) == 0, "rnd");
    end

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule

// File: doc/child_seq_ctrl.md
Name: child_seq_ctrl

Overview:
- Sequencer for a fixed set of NUM_CHILD sub-block instances hosted under one root module.
- Launches the children strictly in index order (0..NUM_CHILD-1) with a one-cycle start pulse. Waits for each child's done before launching the next.
- Reports overall completion, busy status and the index of any child that fails to respond.
- Sits beside the child instances in the parent module; driven by a single start/abort pair from above.

Parameters:
- NUM_CHILD, 5: number of sequenced children, ≥2.
- IDX_W, $clog2(NUM_CHILD): width of the index outputs (derived, not overridden).
- TIMEOUT_W, 8: width of the per-child wait counter.
- TIMEOUT_CYC, 200: WAIT cycles allowed per child, 1..2^TIMEOUT_W-1 (used only with the optional feature).

Ports:
- clk  in  1  single clock; all logic on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start_i  in  1  begin a sequence; sampled only in IDLE or ERROR.
- abort_i  in  1  cancel an in-progress sequence.
- child_start_o  out  NUM_CHILD  one-hot, one-cycle launch pulse per child.
- child_done_i  in  NUM_CHILD  per-child completion pulse or level.
- busy_o  out  1  high in every state except IDLE and ERROR.
- done_o  out  1  one-cycle pulse when the last child completes.
- cur_idx_o  out  IDX_W  index of the child currently launched or awaited.
- err_o  out  1  sticky timeout error.
- err_idx_o  out  IDX_W  index of the child that timed out.

Behaviour:
- Reset: all outputs 0. State IDLE, idx=0, wait counter=0.
- Reset has priority over every input and over any in-flight sequence; the FSM is in IDLE the cycle after rst is sampled high.
- All outputs are registered state or decoded from registered state; no combinational path from any input to any output.
- States: IDLE, LAUNCH, WAIT, FINISH, ERROR.
- IDLE:
  - start_i=1 → LAUNCH, idx←0.
- LAUNCH (exactly one cycle):
  - child_start_o = one-hot(idx), all other bits 0.
  - → WAIT, counter←0.
- WAIT:
  - Only child_done_i[idx] is sampled; done bits of other children are ignored.
  - Done high, idx<NUM_CHILD-1 → idx←idx+1, → LAUNCH.
  - Done high, idx=NUM_CHILD-1 → FINISH.
  - Done held high across the LAUNCH cycle is accepted on the first WAIT cycle.
- FINISH (one cycle):
  - done_o=1, then → IDLE with idx←0.
- Latency:
  - start_i sampled in cycle t → child_start_o[0] high in cycle t+1.
  - child_done_i[k] in cycle t → child_start_o[k+1] in cycle t+1.
  - Final done in cycle t → done_o in cycle t+1.
  - Minimum full sequence: 2·NUM_CHILD+1 cycles from start to done_o.
- abort_i:
  - In LAUNCH, WAIT or FINISH: → IDLE next cycle, no done_o, no child_start_o that cycle, err_o unchanged.
  - Abort wins over a simultaneous child done.
  - Abort in IDLE or ERROR: no effect.
- start_i while busy_o=1: ignored, with no restart and no queuing.
- start_i and abort_i high together in IDLE: start wins.
- cur_idx_o = idx in all states. It holds the last value in ERROR and is 0 in IDLE.
- busy_o: 1 in LAUNCH, WAIT and FINISH.

Optional Feature:
- Macro: CHILD_SEQ_TIMEOUT_EN.
- Defined:
  - WAIT increments the counter every cycle without the awaited done.
  - When the counter reaches TIMEOUT_CYC-1 with no done, the next state is ERROR: err_o←1 and err_idx_o←idx.
  - Done arriving in that same final cycle wins; no error is raised.
  - ERROR holds busy_o=0 and err_o=1.
  - start_i in ERROR clears err_o and err_idx_o and goes to LAUNCH with idx=0.
  - abort_i in ERROR has no effect; only rst or start_i clears err_o.
- Not defined:
  - No counter or ERROR logic; WAIT waits indefinitely.
  - err_o and err_idx_o are tied to 0.

Test Plan:
- Nominal run, NUM_CHILD=5:
  - Stimulus: start_i pulse at cycle 0; each child_done_i[k] returned 3 cycles after its child_start_o[k].
  - Required: child_start_o = 00001, 00010, 00100, 01000, 10000 in order, one cycle each.
  - Required: done_o single pulse exactly one cycle after done[4]; busy_o high from cycle 1 until done_o.
- Zero-delay children:
  - Stimulus: child_done_i tied to 5'b11111.
  - Required: done_o at cycle 11 after start at cycle 0.
- Stray done ignored:
  - Stimulus: done[3] pulsed while waiting on child 1.
  - Required: no advance, cur_idx_o stays 1.
  - Stimulus: start_i re-pulsed mid-sequence.
  - Required: sequence unchanged.
- Abort mid-sequence:
  - Stimulus: abort_i in the same cycle as done[2].
  - Required: IDLE next cycle, no child_start_o[3], no done_o, cur_idx_o=0.
  - Stimulus: new start_i.
  - Required: sequence restarts at child 0.
- Timeout (CHILD_SEQ_TIMEOUT_EN, TIMEOUT_CYC=10):
  - Stimulus: child 2 never responds.
  - Required: err_o=1, err_idx_o=2, busy_o=0 ten cycles after entering WAIT on child 2.
  - Stimulus: start_i.
  - Required: err_o cleared, child_start_o[0] pulses.
- Reset mid-operation:
  - Stimulus: rst asserted for one cycle while in WAIT on child 4.
  - Required: all outputs 0 next cycle, state IDLE, no done_o.
